// File: rtl/rr_packet_mux_pkg.sv
// Shared types and helpers for the round-robin packet multiplexer.
package mux_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  // Width of a channel-index field; never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_packet_mux_pick.sv
// Rotating-priority encoder: the first requester at or after ptr (wrapping) wins.
module rr_pick
  import mux_pkg::*;
#(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned CHW  = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CHW-1:0]  ptr,
  output logic [N_CH-1:0] gnt_onehot,
  output logic [CHW-1:0]  gnt_idx,
  output logic            any
);

  int unsigned c;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    c          = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      c = (32'(ptr) + k) % N_CH;
      if (!any && req[c]) begin
        any           = 1'b1;
        gnt_onehot[c] = 1'b1;
        gnt_idx       = CHW'(c);
      end
    end
  end

endmodule

// File: rtl/rr_packet_mux.sv
// N-channel valid/ready stream mux with round-robin arbitration, packet lock
// and a one-deep registered output stage.
module rr_packet_mux
  import mux_pkg::*;
#(
  parameter  int unsigned N_CH = 4,
  parameter  int unsigned W    = 4,
  localparam int unsigned CHW  = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_last,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic [CHW-1:0]    out_ch,
  input  logic              out_ready
);

  arb_state_t       state_q, state_d;
  logic [CHW-1:0]   ptr_q, ptr_d;
  logic [CHW-1:0]   lock_ch_q, lock_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [CHW-1:0]   out_ch_q, out_ch_d;

  logic [N_CH-1:0]  pick_onehot;
  logic [CHW-1:0]   pick_idx;
  logic             pick_any;

  logic             locked;
  logic             load;
  logic             accept;
  logic [CHW-1:0]   sel_ch;
  logic [N_CH-1:0]  grant;
  logic [W-1:0]     sel_data;
  logic             sel_last;
  logic [CHW-1:0]   sel_next;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req        (in_valid),
    .ptr        (ptr_q),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // While locked the grant is pinned to the owning channel, valid or not.
  always_comb begin
    locked   = (state_q == ARB_LOCKED);
    load     = en && (!out_valid_q || out_ready);
    sel_ch   = locked ? lock_ch_q : pick_idx;
    grant    = locked ? (N_CH'(1) << lock_ch_q) : pick_onehot;
    in_ready = load ? grant : '0;
    accept   = load && (locked ? in_valid[lock_ch_q] : pick_any);
    sel_data = in_data[32'(sel_ch)*W +: W];
    sel_last = in_last[sel_ch];
    sel_next = (sel_ch == CHW'(N_CH - 1)) ? '0 : sel_ch + CHW'(1);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_ch_d   = lock_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_ch_d    = sel_ch;
      if (sel_last) begin
        state_d = ARB_IDLE;
        ptr_d   = sel_next;
      end else begin
        state_d   = ARB_LOCKED;
        lock_ch_d = sel_ch;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      lock_ch_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule
